// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed, checksummed byte stream, writes 32-bit little-endian words
// into instruction memory and releases the CPU from reset once a whole frame has been accepted.
`timescale 1ns/1ps
module imem_boot_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned     LEN_W     = 16;
  localparam int unsigned     TO_W      = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [LEN_W:0]  MAX_WORDS = (LEN_W + 1)'(1) << ADDR_W;
  localparam logic [7:0]      SYNC      = 8'hA5;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, RUN, ERR} stateT;

  stateT             state;
  logic [LEN_W-1:0]  len;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        byteIdx;
  logic [23:0]       wordBuf;
  logic [TO_W-1:0]   idleCnt;

  logic              accept;
  logic              timed;
  logic              lastWord;
  logic [LEN_W-1:0]  lenFull;
  logic              lenBad;

  assign accept   = rx_valid & rx_ready;
  assign timed    = (state == LEN0) | (state == LEN1) | (state == DATA) | (state == CSUM);
  assign lastWord = (LEN_W'(wordIdx) == (len - LEN_W'(1)));
  assign lenFull  = {rx_data, len[7:0]};
  // Zero-length frames and images larger than the memory are rejected up front
  assign lenBad   = (lenFull == '0) | ({1'b0, lenFull} > MAX_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      len        <= '0;
      sum        <= '0;
      wordIdx    <= '0;
      byteIdx    <= '0;
      wordBuf    <= '0;
      idleCnt    <= '0;
    end else begin
      imem_we  <= 1'b0;
      rx_ready <= (state != RUN);

      if (accept || !timed) idleCnt <= '0;
      else                  idleCnt <= idleCnt + TO_W'(1);

      case (state)
        IDLE: begin
          if (accept && (rx_data == SYNC)) state <= LEN0;
        end
        LEN0: begin
          if (accept) begin
            len[7:0] <= rx_data;
            sum      <= rx_data;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            len[15:8] <= rx_data;
            sum       <= sum + rx_data;
            wordIdx   <= '0;
            byteIdx   <= '0;
            if (lenBad) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            sum     <= sum + rx_data;
            byteIdx <= byteIdx + 2'd1;
            case (byteIdx)
              2'd0: wordBuf[7:0]   <= rx_data;
              2'd1: wordBuf[15:8]  <= rx_data;
              2'd2: wordBuf[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= wordIdx;
                imem_wdata <= {rx_data, wordBuf};
                wordIdx    <= wordIdx + ADDR_W'(1);
                if (lastWord) state <= CSUM;
              end
            endcase
          end
        end
        CSUM: begin
          if (accept) begin
            if (rx_data == sum) begin
              state    <= RUN;
              rx_ready <= 1'b0;
              cpu_rst  <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        RUN: ;
        ERR: begin
          if (accept && (rx_data == SYNC)) begin
            state <= LEN0;
            err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort a stalled frame; an accepted byte in the same cycle takes precedence
      if (timed && !accept && (idleCnt == TO_LAST)) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (ADDR_W=8, TIMEOUT=16): framing, checksum, length limits,
// inter-byte timeout and asynchronous reset.
`timescale 1ns/1ps
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  logic [7:0]  frame[$];

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  // Record every memory write strobe
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wrAddr.push_back(32'(imem_addr));
      wrData.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    @(negedge clk);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendFrame(input int gap);
    foreach (frame[i]) sendByte(frame[i], gap);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"},       32'(imem_we),  32'd0);
    check({tag, "_addr"},     32'(imem_addr), 32'd0);
    check({tag, "_wdata"},    imem_wdata,    32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    #1;
    checkResetOutputs(tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, "_ready_first_cycle"}, 32'(rx_ready), 32'd0);
    wrAddr.delete();
    wrData.delete();
  endtask

  task automatic checkLoaded(input string tag);
    check({tag, "_nwrites"}, 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() >= 2) begin
      check({tag, "_addr0"},  wrAddr[0], 32'd0);
      check({tag, "_data0"},  wrData[0], 32'h4433_2211);
      check({tag, "_addr1"},  wrAddr[1], 32'd1);
      check({tag, "_data1"},  wrData[1], 32'h8877_6655);
    end
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd0);
    check({tag, "_done"},     32'(done),     32'd1);
    check({tag, "_err"},      32'(err),      32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
  endtask

  task automatic setGoodFrame();
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h66};
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Test 1: back-to-back good frame
    doReset("t1_reset");
    setGoodFrame();
    sendFrame(0);
    checkLoaded("t1");

    // Test 2: bad checksum, then recovery with a good frame
    doReset("t2_reset");
    setGoodFrame();
    frame[11] = 8'h67;
    sendFrame(0);
    check("t2_bad_err",      32'(err),      32'd1);
    check("t2_bad_cpu_rst",  32'(cpu_rst),  32'd1);
    check("t2_bad_done",     32'(done),     32'd0);
    check("t2_bad_rx_ready", 32'(rx_ready), 32'd1);
    check("t2_bad_nwrites",  32'(wrAddr.size()), 32'd2);
    wrAddr.delete();
    wrData.delete();
    setGoodFrame();
    sendFrame(0);
    checkLoaded("t2_retry");

    // Test 3: junk bytes before sync are ignored
    doReset("t3_reset");
    sendByte(8'h00, 0);
    sendByte(8'hFF, 0);
    sendByte(8'h5A, 0);
    check("t3_junk_nwrites", 32'(wrAddr.size()), 32'd0);
    setGoodFrame();
    sendFrame(0);
    checkLoaded("t3");

    // Test 4: zero length and oversize length rejected
    doReset("t4_reset");
    frame = '{8'hA5, 8'h00, 8'h00};
    sendFrame(0);
    check("t4_len0_err",     32'(err),      32'd1);
    check("t4_len0_rx_ready",32'(rx_ready), 32'd1);
    sendByte(8'hA5, 0);
    check("t4_sync_clears_err", 32'(err), 32'd0);
    sendByte(8'h01, 0);
    sendByte(8'h01, 0);
    check("t4_len257_err",   32'(err),      32'd1);
    check("t4_cpu_rst",      32'(cpu_rst),  32'd1);
    check("t4_done",         32'(done),     32'd0);
    check("t4_nwrites",      32'(wrAddr.size()), 32'd0);

    // Test 5a: 16 idle cycles after the 3rd data byte abort the frame
    doReset("t5_reset");
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    sendFrame(0);
    sendByte(8'h44, 16);
    frame = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h66};
    sendFrame(0);
    check("t5a_nwrites",  32'(wrAddr.size()), 32'd0);
    check("t5a_done",     32'(done),     32'd0);
    check("t5a_err",      32'(err),      32'd0);
    check("t5a_cpu_rst",  32'(cpu_rst),  32'd1);
    check("t5a_rx_ready", 32'(rx_ready), 32'd1);

    // Test 5b: 15-cycle gaps everywhere still load
    setGoodFrame();
    sendFrame(15);
    checkLoaded("t5b");

    // Test 6: asynchronous reset mid-DATA while a write strobe is live
    doReset("t6_reset");
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    sendFrame(0);
    check("t6_we_live", 32'(imem_we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkResetOutputs("t6_async");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_ready_first_cycle", 32'(rx_ready), 32'd0);
    wrAddr.delete();
    wrData.delete();
    setGoodFrame();
    sendFrame(0);
    checkLoaded("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
